occupancy_sampler: RTL and testbench

- Read-side companion to the occupancy grid writer. Accepts one map query (x, y) and fetches the 2x2 cell neighbourhood (x,y), (x+1,y), (x,y+1), (x+1,y+1) from the grid memory read port.
- Returns the four cell values and out-of-map flags to the scan-matching datapath, where they feed bilinear map interpolation and gradients.
- Stalls while the grid writer reports busy, so a read never observes a half-updated map.

---
 rtl/occupancy_sampler.sv | 138 +++++++++++++
 tb/tb_occupancy_sampler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_sampler.sv
// occupancy_sampler
//   Read-side companion to the occupancy grid writer. Takes one map query
//   (x, y), fetches the 2x2 neighbourhood (x,y) (x+1,y) (x,y+1) (x+1,y+1)
//   from the grid memory read port and returns the four cell values plus
//   per-neighbour out-of-map flags. Reads are never issued while the grid
//   writer is busy, so a result never mixes old and new map contents.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid && ready. A producer holds valid and its payload stable until the
//   transfer; ready may change freely.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   req_valid/req_ready     query handshake, req_x / req_y query cell
//   grid_busy               writer busy; suppresses read issue
//   mem_re/mem_addr         read port, address {y, x}
//   mem_data                read data, valid the cycle after mem_re
//   resp_valid/resp_ready   result handshake
//   resp_m00..resp_m11      cells (x,y) (x+1,y) (x,y+1) (x+1,y+1)
//   resp_oob                out-of-map flags, bit order [m11,m01,m10,m00]
//   dbg_state               current FSM state (IDLE=0 FETCH=1 DRAIN=2 RESP=3)
module occupancy_sampler #(
  parameter int X_WIDTH = 5,
  parameter int Y_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] UNKNOWN_VALUE = 8'h80
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [X_WIDTH-1:0]         req_x,
  input  logic [Y_WIDTH-1:0]         req_y,
  input  logic                       grid_busy,
  output logic                       mem_re,
  output logic [X_WIDTH+Y_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_WIDTH-1:0]      resp_m00,
  output logic [DATA_WIDTH-1:0]      resp_m10,
  output logic [DATA_WIDTH-1:0]      resp_m01,
  output logic [DATA_WIDTH-1:0]      resp_m11,
  output logic [3:0]                 resp_oob,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                       state, state_next;
  logic [X_WIDTH-1:0]           x_q;
  logic [Y_WIDTH-1:0]           y_q;
  logic [3:0]                   oob_q;
  logic [1:0]                   k_q;
  logic                         pend_q;
  logic [1:0]                   pend_slot_q;
  logic [X_WIDTH+Y_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]        slot [4];
  logic                         fetch_step;
  logic [X_WIDTH+Y_WIDTH-1:0]   rd_addr;
  logic                         x_max, y_max;

  // Neighbour k: bit0 selects x+1, bit1 selects y+1. Only used when the
  // neighbour is in map, so the increments never wrap.
  assign rd_addr = {y_q + Y_WIDTH'(k_q[1]), x_q + X_WIDTH'(k_q[0])};
  assign x_max   = &req_x;
  assign y_max   = &req_y;

  always_comb begin
    state_next = state;
    mem_re     = 1'b0;
    fetch_step = 1'b0;
    case (state)
      IDLE: if (req_valid) state_next = FETCH;
      FETCH: begin
        if (!grid_busy) begin
          fetch_step = 1'b1;
          mem_re     = !oob_q[k_q];
          if (k_q == 2'd3) state_next = DRAIN;
        end
      end
      DRAIN: state_next = RESP;
      RESP:  if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // Address is held from the last issued read when no read is active.
  assign mem_addr   = mem_re ? rd_addr : addr_q;
  assign resp_m00   = slot[0];
  assign resp_m10   = slot[1];
  assign resp_m01   = slot[2];
  assign resp_m11   = slot[3];
  assign resp_oob   = oob_q;
  assign dbg_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      oob_q       <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      addr_q      <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        x_q   <= req_x;
        y_q   <= req_y;
        oob_q <= {x_max | y_max, y_max, x_max, 1'b0};
        k_q   <= '0;
      end
      if (fetch_step) k_q <= k_q + 2'd1;
      // Capture pipeline: a read issued this cycle lands in its slot next
      // cycle, independent of grid_busy at that point.
      pend_q <= mem_re;
      if (mem_re) begin
        pend_slot_q <= k_q;
        addr_q      <= rd_addr;
      end
      if (pend_q) slot[pend_slot_q] <= mem_data;
      // Out-of-map neighbours still take their own fetch cycle so latency
      // does not depend on the query position.
      if (fetch_step && oob_q[k_q]) slot[k_q] <= UNKNOWN_VALUE;
    end
  end

endmodule

// File: tb/tb_occupancy_sampler.sv
// Directed bench for occupancy_sampler. Memory model returns cell(a) = a[7:0]
// one cycle after a read; inputs are driven and outputs sampled on the
// falling edge.
module tb_occupancy_sampler;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_x;
  logic [3:0] req_y;
  logic       grid_busy;
  logic       mem_re;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_m00, resp_m10, resp_m01, resp_m11;
  logic [3:0] resp_oob;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  int busy_viol = 0;
  logic [8:0] exp_q[$];
  logic [8:0] rd_q[$];

  occupancy_sampler dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .grid_busy(grid_busy),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_m00(resp_m00), .resp_m10(resp_m10),
    .resp_m01(resp_m01), .resp_m11(resp_m11),
    .resp_oob(resp_oob), .dbg_state(dbg_state)
  );

  // clock block
  always #5 clock = ~clock;

  // grid memory model and read log
  always @(posedge clock) begin
    if (mem_re) begin
      mem_data <= mem_addr[7:0];
      rd_q.push_back(mem_addr);
      if (grid_busy) busy_viol++;
    end else begin
      mem_data <= 8'h5a;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a query and wait for resp_valid; optional grid_busy window.
  task automatic run_query(input int x, input int y, input int exp_lat,
                           input int busy_start, input int busy_len);
    int lat;
    bit got;
    rd_q.delete();
    busy_viol = 0;
    req_valid = 1'b1;
    req_x = 5'(x);
    req_y = 4'(y);
    check("req_ready_idle", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_x = 5'($urandom_range(0, 31));
    req_y = 4'($urandom_range(0, 15));
    check("req_ready_fetch", req_ready, 0);
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (busy_len > 0 && lat == busy_start) grid_busy = 1'b1;
      if (busy_len > 0 && lat == busy_start + busy_len) grid_busy = 1'b0;
      if (resp_valid) got = 1;
    end
    check("resp_seen", got, 1);
    check("latency", lat, exp_lat);
  endtask

  task automatic check_resp(input logic [7:0] e00, input logic [7:0] e10,
                            input logic [7:0] e01, input logic [7:0] e11,
                            input logic [3:0] eoob);
    check("m00", resp_m00, e00);
    check("m10", resp_m10, e10);
    check("m01", resp_m01, e01);
    check("m11", resp_m11, e11);
    check("oob", resp_oob, eoob);
    check("rd_count", rd_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
      check("rd_addr", rd_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check("resp_valid_after_hs", resp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_x = '0;
    req_y = '0;
    grid_busy = 1'b0;
    resp_ready = 1'b0;
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_m00", resp_m00, 0);
    check("rst_m11", resp_m11, 0);
    check("rst_oob", resp_oob, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // interior query
    exp_q = '{9'd67, 9'd68, 9'd99, 9'd100};
    run_query(3, 2, 5, 0, 0);
    check("state_resp", dbg_state, 3);
    check_resp(8'h43, 8'h44, 8'h63, 8'h64, 4'b0000);
    finish_resp();

    // corner query: only m00 read
    exp_q = '{9'd511};
    run_query(31, 15, 5, 0, 0);
    check_resp(8'hff, 8'h80, 8'h80, 8'h80, 4'b1110);
    finish_resp();

    // right edge
    exp_q = '{9'd159, 9'd191};
    run_query(31, 4, 5, 0, 0);
    check_resp(8'h9f, 8'h80, 8'hbf, 8'h80, 4'b1010);
    finish_resp();

    // bottom edge
    exp_q = '{9'd490, 9'd491};
    run_query(10, 15, 5, 0, 0);
    check_resp(8'hea, 8'heb, 8'h80, 8'h80, 4'b1100);
    finish_resp();

    // stall for 3 cycles after the first read
    exp_q = '{9'd229, 9'd230, 9'd261, 9'd262};
    run_query(5, 7, 8, 1, 3);
    check_resp(8'he5, 8'he6, 8'h05, 8'h06, 4'b0000);
    check("busy_reads", busy_viol, 0);
    finish_resp();

    // backpressure, then a back-to-back query
    exp_q = '{9'd0, 9'd1, 9'd32, 9'd33};
    run_query(0, 0, 5, 0, 0);
    check_resp(8'h00, 8'h01, 8'h20, 8'h21, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("bp_valid", resp_valid, 1);
      check("bp_m10", resp_m10, 8'h01);
      check("bp_m11", resp_m11, 8'h21);
      check("bp_req_ready", req_ready, 0);
    end
    finish_resp();
    exp_q = '{9'd478, 9'd479, 9'd510, 9'd511};
    run_query(30, 14, 5, 0, 0);
    check_resp(8'hde, 8'hdf, 8'hfe, 8'hff, 4'b0000);
    finish_resp();

    // reset during FETCH with k=2
    req_valid = 1'b1;
    req_x = 5'd12;
    req_y = 4'd9;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    check("k2_state", dbg_state, 1);
    check("k2_mem_re", mem_re, 1);
    check("k2_addr", mem_addr, 9'd332);
    reset = 1'b1;
    #1;
    check("abort_resp_valid", resp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_mem_re", mem_re, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    exp_q = '{9'd33, 9'd34, 9'd65, 9'd66};
    run_query(1, 1, 5, 0, 0);
    check_resp(8'h21, 8'h22, 8'h41, 8'h42, 4'b0000);
    finish_resp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
